// File: rtl/mmx_pkg.sv
// Shared types and constants for the MMX register-read scoreboard.
package mmx_pkg;

  localparam int unsigned MM_IDX_W = 3;
  localparam int unsigned NUM_MM   = 8;
  localparam int unsigned CNT_W    = 2;

  typedef logic [MM_IDX_W-1:0] mm_idx_t;
  typedef logic [CNT_W-1:0]    mm_cnt_t;

  function automatic mm_cnt_t cnt_max();
    return '1;
  endfunction

endpackage

// File: rtl/mmx_pend_cnt.sv
// Per-register outstanding-write counter; saturates at cnt_max and never drops below zero.
module mmx_pend_cnt
  import mmx_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic zero,
  output logic full
);

  mm_cnt_t cnt_q, cnt_d;
  logic    dec_eff;

  assign zero = (cnt_q == '0);
  assign full = (cnt_q == cnt_max());

  always_comb begin
    cnt_d   = cnt_q;
    dec_eff = dec & ~zero;
    // Simultaneous retire and new write cancel out.
    if (inc && !dec_eff && !full) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_eff && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mmx_scoreboard.sv
// MMX register-read stage: RAW/saturation/backpressure stall, output register and
// per-register pending-write tracking retired by writeback.
module mmx_scoreboard
  import mmx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              dec_valid,
  input  logic              mm1_needed,
  input  logic              mm2_needed,
  input  logic [2:0]        mm1,
  input  logic [2:0]        mm2,
  input  logic [2:0]        dmm,
  input  logic              ld_mm,
  input  logic              flush,
  input  logic              rr_ready,
  input  logic              wb_valid,
  input  logic [2:0]        wb_mm,
  output logic              dec_stall,
  output logic              rr_valid,
  output logic [2:0]        rr_mm1,
  output logic [2:0]        rr_mm2,
  output logic [2:0]        rr_dmm,
  output logic              rr_ld_mm,
  output logic [NUM_MM-1:0] busy_vec,
  output logic              sb_err
);

  logic [NUM_MM-1:0] zero, full, inc, dec;
  logic              raw1, raw2, sat, out_block, issue;

  logic    rr_valid_q, rr_valid_d;
  mm_idx_t rr_mm1_q, rr_mm1_d;
  mm_idx_t rr_mm2_q, rr_mm2_d;
  mm_idx_t rr_dmm_q, rr_dmm_d;
  logic    rr_ld_mm_q, rr_ld_mm_d;
  logic    sb_err_q, sb_err_d;

  for (genvar i = 0; i < NUM_MM; i++) begin : g_cnt
    assign inc[i] = issue & ld_mm & (dmm == mm_idx_t'(i));
    assign dec[i] = wb_valid & (wb_mm == mm_idx_t'(i));

    mmx_pend_cnt u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc[i]),
      .dec  (dec[i]),
      .zero (zero[i]),
      .full (full[i])
    );
  end

  // No writeback bypass: a register retiring this cycle still blocks its reader.
  always_comb begin
    raw1      = mm1_needed & ~zero[mm1];
    raw2      = mm2_needed & ~zero[mm2];
    sat       = ld_mm & full[dmm];
    out_block = rr_valid_q & ~rr_ready;
    dec_stall = dec_valid & ~flush & (raw1 | raw2 | sat | out_block);
    issue     = dec_valid & ~flush & ~dec_stall;
  end

  always_comb begin
    rr_valid_d = rr_valid_q;
    rr_mm1_d   = rr_mm1_q;
    rr_mm2_d   = rr_mm2_q;
    rr_dmm_d   = rr_dmm_q;
    rr_ld_mm_d = rr_ld_mm_q;
    if (flush) begin
      rr_valid_d = 1'b0;
    end else if (issue) begin
      rr_valid_d = 1'b1;
      rr_mm1_d   = mm1;
      rr_mm2_d   = mm2;
      rr_dmm_d   = dmm;
      rr_ld_mm_d = ld_mm;
    end else if (rr_ready) begin
      rr_valid_d = 1'b0;
    end
    sb_err_d = sb_err_q | (wb_valid & zero[wb_mm]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_valid_q <= 1'b0;
      rr_mm1_q   <= '0;
      rr_mm2_q   <= '0;
      rr_dmm_q   <= '0;
      rr_ld_mm_q <= 1'b0;
      sb_err_q   <= 1'b0;
    end else begin
      rr_valid_q <= rr_valid_d;
      rr_mm1_q   <= rr_mm1_d;
      rr_mm2_q   <= rr_mm2_d;
      rr_dmm_q   <= rr_dmm_d;
      rr_ld_mm_q <= rr_ld_mm_d;
      sb_err_q   <= sb_err_d;
    end
  end

  assign rr_valid = rr_valid_q;
  assign rr_mm1   = rr_mm1_q;
  assign rr_mm2   = rr_mm2_q;
  assign rr_dmm   = rr_dmm_q;
  assign rr_ld_mm = rr_ld_mm_q;
  assign busy_vec = ~zero;
  assign sb_err   = sb_err_q;

endmodule

// File: tb/tb_mmx_scoreboard.sv
// Directed table-driven bench for mmx_scoreboard plus a self-dependency sequence.
module tb_mmx_scoreboard;

  logic       clk;
  logic       rst;
  logic       dec_valid, mm1_needed, mm2_needed, ld_mm, flush, rr_ready, wb_valid;
  logic [2:0] mm1, mm2, dmm, wb_mm;
  logic       dec_stall, rr_valid, rr_ld_mm, sb_err;
  logic [2:0] rr_mm1, rr_mm2, rr_dmm;
  logic [7:0] busy_vec;

  int checks = 0;
  int errors = 0;

  mmx_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .dec_valid  (dec_valid),
    .mm1_needed (mm1_needed),
    .mm2_needed (mm2_needed),
    .mm1        (mm1),
    .mm2        (mm2),
    .dmm        (dmm),
    .ld_mm      (ld_mm),
    .flush      (flush),
    .rr_ready   (rr_ready),
    .wb_valid   (wb_valid),
    .wb_mm      (wb_mm),
    .dec_stall  (dec_stall),
    .rr_valid   (rr_valid),
    .rr_mm1     (rr_mm1),
    .rr_mm2     (rr_mm2),
    .rr_dmm     (rr_dmm),
    .rr_ld_mm   (rr_ld_mm),
    .busy_vec   (busy_vec),
    .sb_err     (sb_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int rst, dv, m1n, m2n, mm1, mm2, dmm, ld, fl, rdy, wbv, wbm;
    int e_stall, e_rv, e_mm1, e_dmm, e_busy, e_err;
  } vec_t;

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst        = v.rst[0];
    dec_valid  = v.dv[0];
    mm1_needed = v.m1n[0];
    mm2_needed = v.m2n[0];
    mm1        = 3'(v.mm1);
    mm2        = 3'(v.mm2);
    dmm        = 3'(v.dmm);
    ld_mm      = v.ld[0];
    flush      = v.fl[0];
    rr_ready   = v.rdy[0];
    wb_valid   = v.wbv[0];
    wb_mm      = 3'(v.wbm);
  endtask

  vec_t tv[23];

  initial begin
    //        rst dv m1n m2n mm1 mm2 dmm ld fl rdy wbv wbm  stall rv mm1 dmm busy err
    tv[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00, 0};
    tv[1]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 'h00, 0};
    tv[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 'h00, 0};
    // write r3, then reader of r3 stalls through the writeback cycle
    tv[3]  = '{0, 1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0,   0, 1, 0, 3, 'h08, 0};
    tv[4]  = '{0, 1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 3, 'h08, 0};
    tv[5]  = '{0, 1, 1, 0, 3, 0, 0, 0, 0, 1, 1, 3,   1, 0, 0, 3, 'h00, 0};
    tv[6]  = '{0, 1, 1, 0, 3, 0, 0, 0, 0, 1, 0, 0,   0, 1, 3, 0, 'h00, 0};
    // saturate r5
    tv[7]  = '{0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0,   0, 1, 0, 5, 'h20, 0};
    tv[8]  = '{0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0,   0, 1, 0, 5, 'h20, 0};
    tv[9]  = '{0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0,   0, 1, 0, 5, 'h20, 0};
    tv[10] = '{0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 1, 5,   1, 0, 0, 5, 'h20, 0};
    tv[11] = '{0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0,   0, 1, 0, 5, 'h20, 0};
    tv[12] = '{0, 1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0,   1, 0, 0, 5, 'h20, 0};
    // simultaneous inc/dec on r2
    tv[13] = '{0, 1, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0,   0, 1, 0, 2, 'h24, 0};
    tv[14] = '{0, 1, 0, 0, 0, 0, 2, 1, 0, 1, 1, 2,   0, 1, 0, 2, 'h24, 0};
    tv[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2,   0, 0, 0, 2, 'h20, 0};
    // backpressure then flush
    tv[16] = '{0, 1, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0,   0, 1, 0, 1, 'h22, 0};
    tv[17] = '{0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0,   1, 1, 0, 1, 'h22, 0};
    tv[18] = '{0, 1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0,   0, 0, 0, 1, 'h22, 0};
    // spurious writeback, sticky error, reset with writeback ignored
    tv[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7,   0, 0, 0, 1, 'h22, 1};
    tv[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 'h22, 1};
    tv[21] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1,   0, 0, 0, 0, 'h00, 0};
    tv[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 'h00, 0};

    drive(tv[0]);
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      drive(tv[i]);
      #1;
      chk("dec_stall", i, int'(dec_stall), tv[i].e_stall);
      @(posedge clk);
      #1;
      chk("rr_valid", i, int'(rr_valid), tv[i].e_rv);
      chk("rr_mm1", i, int'(rr_mm1), tv[i].e_mm1);
      chk("rr_dmm", i, int'(rr_dmm), tv[i].e_dmm);
      chk("busy_vec", i, int'(busy_vec), tv[i].e_busy);
      chk("sb_err", i, int'(sb_err), tv[i].e_err);
    end

    // Self-dependency: mm1 == dmm with r6 idle issues and marks r6 busy.
    @(negedge clk);
    drive('{0, 1, 1, 1, 6, 2, 6, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0});
    #1;
    chk("selfdep_stall", 100, int'(dec_stall), 0);
    @(posedge clk);
    #1;
    chk("selfdep_rv", 100, int'(rr_valid), 1);
    chk("selfdep_mm1", 100, int'(rr_mm1), 6);
    chk("selfdep_mm2", 100, int'(rr_mm2), 2);
    chk("selfdep_dmm", 100, int'(rr_dmm), 6);
    chk("selfdep_ld", 100, int'(rr_ld_mm), 1);
    chk("selfdep_busy", 100, int'(busy_vec), 'h40);
    // Same instruction again now hazards on its own pending write.
    @(negedge clk);
    #1;
    chk("selfdep_raw", 101, int'(dec_stall), 1);
    @(negedge clk);
    drive('{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0, 0, 0, 0, 0, 0});
    @(posedge clk);
    #1;
    chk("selfdep_retire", 102, int'(busy_vec), 'h00);
    chk("selfdep_err", 102, int'(sb_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
